// File: rtl/fpu_instruction_decoder.sv
// Registered decoder for 8087 escape instructions (D8-DF + ModRM).
// Turns one instruction word into a micro-opcode, an ST(i) index and
// operand attributes for the FPU sequencer; unknown encodings decode to
// all-zero with valid=0.
module fpu_instruction_decoder (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instruction,
  input  logic        decode,
  output logic [7:0]  internal_opcode,
  output logic [2:0]  stack_index,
  output logic        has_memory_op,
  output logic        has_pop,
  output logic        has_push,
  output logic        is_integer,
  output logic        is_bcd,
  output logic [1:0]  operand_size,
  output logic        uses_st0_sti,
  output logic        uses_sti_st0,
  output logic        valid
);

  logic [7:0] esc;
  logic [7:0] modrm;
  logic [1:0] mod_f;
  logic [2:0] reg_f;
  logic [2:0] rm_f;

  assign esc   = instruction[15:8];
  assign modrm = instruction[7:0];
  assign mod_f = modrm[7:6];
  assign reg_f = modrm[5:3];
  assign rm_f  = modrm[2:0];

  logic [7:0] arith_op;
  logic [7:0] rev_arith_op;

  // Arithmetic group selected by reg; DC register form swaps SUB/SUBR and DIV/DIVR
  always_comb begin
    arith_op     = 8'h00;
    rev_arith_op = 8'h00;
    case (reg_f)
      3'd0: begin arith_op = 8'h10; rev_arith_op = 8'h10; end
      3'd1: begin arith_op = 8'h16; rev_arith_op = 8'h16; end
      3'd2: begin arith_op = 8'h60; rev_arith_op = 8'h60; end
      3'd3: begin arith_op = 8'h61; rev_arith_op = 8'h61; end
      3'd4: begin arith_op = 8'h12; rev_arith_op = 8'h14; end
      3'd5: begin arith_op = 8'h14; rev_arith_op = 8'h12; end
      3'd6: begin arith_op = 8'h18; rev_arith_op = 8'h1A; end
      default: begin arith_op = 8'h1A; rev_arith_op = 8'h18; end
    endcase
  end

  logic [7:0] n_op;
  logic [2:0] n_idx;
  logic       n_mem;
  logic       n_pop;
  logic       n_push;
  logic       n_int;
  logic       n_bcd;
  logic [1:0] n_size;
  logic       n_s0si;
  logic       n_sis0;
  logic       n_valid;

  // Full decode of the current instruction word into next-state output values
  always_comb begin
    n_op    = 8'h00;
    n_idx   = 3'd0;
    n_mem   = 1'b0;
    n_pop   = 1'b0;
    n_push  = 1'b0;
    n_int   = 1'b0;
    n_bcd   = 1'b0;
    n_size  = 2'd0;
    n_s0si  = 1'b0;
    n_sis0  = 1'b0;
    n_valid = 1'b0;

    if (esc[7:3] == 5'b11011) begin
      if (mod_f != 2'b11) begin
        case (esc[2:0])
          3'd0, 3'd2, 3'd4, 3'd6: begin
            n_valid = 1'b1;
            n_op    = arith_op;
            n_pop   = (reg_f == 3'd3);
            n_int   = esc[1];
            if (!esc[2])     n_size = 2'd1;
            else if (esc[1]) n_size = 2'd0;
            else             n_size = 2'd2;
          end
          3'd1: begin
            case (reg_f)
              3'd0: begin n_valid = 1'b1; n_op = 8'h20; n_push = 1'b1; n_size = 2'd1; end
              3'd2: begin n_valid = 1'b1; n_op = 8'h21; n_size = 2'd1; end
              3'd3: begin n_valid = 1'b1; n_op = 8'h22; n_pop = 1'b1; n_size = 2'd1; end
              3'd4: begin n_valid = 1'b1; n_op = 8'hF6; end
              3'd5: begin n_valid = 1'b1; n_op = 8'hF1; end
              3'd6: begin n_valid = 1'b1; n_op = 8'hF7; end
              3'd7: begin n_valid = 1'b1; n_op = 8'hF2; end
              default: ;
            endcase
          end
          3'd3: begin
            case (reg_f)
              3'd0: begin n_valid = 1'b1; n_op = 8'h20; n_push = 1'b1; n_int = 1'b1; n_size = 2'd1; end
              3'd2: begin n_valid = 1'b1; n_op = 8'h21; n_int = 1'b1; n_size = 2'd1; end
              3'd3: begin n_valid = 1'b1; n_op = 8'h22; n_pop = 1'b1; n_int = 1'b1; n_size = 2'd1; end
              3'd5: begin n_valid = 1'b1; n_op = 8'h20; n_push = 1'b1; n_size = 2'd3; end
              3'd7: begin n_valid = 1'b1; n_op = 8'h22; n_pop = 1'b1; n_size = 2'd3; end
              default: ;
            endcase
          end
          3'd5: begin
            case (reg_f)
              3'd0: begin n_valid = 1'b1; n_op = 8'h20; n_push = 1'b1; n_size = 2'd2; end
              3'd2: begin n_valid = 1'b1; n_op = 8'h21; n_size = 2'd2; end
              3'd3: begin n_valid = 1'b1; n_op = 8'h22; n_pop = 1'b1; n_size = 2'd2; end
              3'd4: begin n_valid = 1'b1; n_op = 8'hF9; end
              3'd6: begin n_valid = 1'b1; n_op = 8'hF8; end
              3'd7: begin n_valid = 1'b1; n_op = 8'hF3; end
              default: ;
            endcase
          end
          default: begin
            case (reg_f)
              3'd0: begin n_valid = 1'b1; n_op = 8'h20; n_push = 1'b1; n_int = 1'b1; end
              3'd2: begin n_valid = 1'b1; n_op = 8'h21; n_int = 1'b1; end
              3'd3: begin n_valid = 1'b1; n_op = 8'h22; n_pop = 1'b1; n_int = 1'b1; end
              3'd4: begin n_valid = 1'b1; n_op = 8'h20; n_push = 1'b1; n_bcd = 1'b1; n_size = 2'd3; end
              3'd5: begin n_valid = 1'b1; n_op = 8'h20; n_push = 1'b1; n_int = 1'b1; n_size = 2'd2; end
              3'd6: begin n_valid = 1'b1; n_op = 8'h22; n_pop = 1'b1; n_bcd = 1'b1; n_size = 2'd3; end
              3'd7: begin n_valid = 1'b1; n_op = 8'h22; n_pop = 1'b1; n_int = 1'b1; n_size = 2'd2; end
              default: ;
            endcase
          end
        endcase
        n_mem = n_valid;
      end else begin
        n_idx = rm_f;
        case (esc[2:0])
          3'd0: begin
            n_valid = 1'b1;
            n_op    = arith_op;
            n_pop   = (reg_f == 3'd3);
            n_s0si  = 1'b1;
          end
          3'd1: begin
            if (reg_f == 3'd0) begin
              n_valid = 1'b1; n_op = 8'h20; n_push = 1'b1;
            end else if (reg_f == 3'd1) begin
              n_valid = 1'b1; n_op = 8'h23;
            end else begin
              case (modrm)
                8'hD0: begin n_valid = 1'b1; n_op = 8'hF5; end
                8'hE0: begin n_valid = 1'b1; n_op = 8'h95; end
                8'hE1: begin n_valid = 1'b1; n_op = 8'h94; end
                8'hE4: begin n_valid = 1'b1; n_op = 8'h63; end
                8'hE5: begin n_valid = 1'b1; n_op = 8'h64; end
                8'hE8: begin n_valid = 1'b1; n_op = 8'h80; n_push = 1'b1; end
                8'hE9: begin n_valid = 1'b1; n_op = 8'h84; n_push = 1'b1; end
                8'hEA: begin n_valid = 1'b1; n_op = 8'h83; n_push = 1'b1; end
                8'hEB: begin n_valid = 1'b1; n_op = 8'h82; n_push = 1'b1; end
                8'hEC: begin n_valid = 1'b1; n_op = 8'h85; n_push = 1'b1; end
                8'hED: begin n_valid = 1'b1; n_op = 8'h86; n_push = 1'b1; end
                8'hEE: begin n_valid = 1'b1; n_op = 8'h81; n_push = 1'b1; end
                8'hF0: begin n_valid = 1'b1; n_op = 8'h56; end
                8'hF1: begin n_valid = 1'b1; n_op = 8'h57; n_pop = 1'b1; end
                8'hF2: begin n_valid = 1'b1; n_op = 8'h54; n_push = 1'b1; end
                8'hF3: begin n_valid = 1'b1; n_op = 8'h55; n_pop = 1'b1; end
                8'hF4: begin n_valid = 1'b1; n_op = 8'h98; n_push = 1'b1; end
                8'hF6: begin n_valid = 1'b1; n_op = 8'h71; end
                8'hF7: begin n_valid = 1'b1; n_op = 8'h70; end
                8'hF8: begin n_valid = 1'b1; n_op = 8'h99; end
                8'hF9: begin n_valid = 1'b1; n_op = 8'h58; n_pop = 1'b1; end
                8'hFA: begin n_valid = 1'b1; n_op = 8'h50; end
                8'hFB: begin n_valid = 1'b1; n_op = 8'h53; n_push = 1'b1; end
                8'hFC: begin n_valid = 1'b1; n_op = 8'h96; end
                8'hFD: begin n_valid = 1'b1; n_op = 8'h97; end
                8'hFE: begin n_valid = 1'b1; n_op = 8'h51; end
                8'hFF: begin n_valid = 1'b1; n_op = 8'h52; end
                default: ;
              endcase
              if (modrm[7:5] == 3'b111) n_idx = 3'd0;
            end
          end
          3'd3: begin
            if (modrm == 8'hE2) begin n_valid = 1'b1; n_op = 8'hF4; n_idx = 3'd0; end
            if (modrm == 8'hE3) begin n_valid = 1'b1; n_op = 8'hF0; n_idx = 3'd0; end
          end
          3'd4: begin
            n_valid = 1'b1;
            n_op    = rev_arith_op;
            n_pop   = (reg_f == 3'd3);
            n_sis0  = 1'b1;
          end
          3'd5: begin
            case (reg_f)
              3'd0: begin n_valid = 1'b1; n_op = 8'h72; end
              3'd2: begin n_valid = 1'b1; n_op = 8'h21; end
              3'd3: begin n_valid = 1'b1; n_op = 8'h22; n_pop = 1'b1; end
              default: ;
            endcase
          end
          3'd6: begin
            if (reg_f != 3'd2 && reg_f != 3'd3) begin
              n_valid = 1'b1;
              n_op    = arith_op | 8'h01;
              n_pop   = 1'b1;
              n_sis0  = 1'b1;
            end else if (modrm == 8'hD9) begin
              n_valid = 1'b1; n_op = 8'h62; n_pop = 1'b1;
            end
          end
          3'd7: begin
            if (modrm == 8'hE0) begin n_valid = 1'b1; n_op = 8'hF3; n_idx = 3'd0; end
            if (modrm == 8'hF6) begin n_valid = 1'b1; n_op = 8'h71; end
            if (modrm == 8'hF7) begin n_valid = 1'b1; n_op = 8'h70; end
          end
          default: ;
        endcase
      end
    end

    if (!n_valid) begin
      n_op   = 8'h00;
      n_idx  = 3'd0;
      n_mem  = 1'b0;
      n_pop  = 1'b0;
      n_push = 1'b0;
      n_int  = 1'b0;
      n_bcd  = 1'b0;
      n_size = 2'd0;
      n_s0si = 1'b0;
      n_sis0 = 1'b0;
    end
  end

  // Output register: cleared by reset, loaded on decode, otherwise held
  always_ff @(posedge clk) begin
    if (reset) begin
      internal_opcode <= 8'h00;
      stack_index     <= 3'd0;
      has_memory_op   <= 1'b0;
      has_pop         <= 1'b0;
      has_push        <= 1'b0;
      is_integer      <= 1'b0;
      is_bcd          <= 1'b0;
      operand_size    <= 2'd0;
      uses_st0_sti    <= 1'b0;
      uses_sti_st0    <= 1'b0;
      valid           <= 1'b0;
    end else if (decode) begin
      internal_opcode <= n_op;
      stack_index     <= n_idx;
      has_memory_op   <= n_mem;
      has_pop         <= n_pop;
      has_push        <= n_push;
      is_integer      <= n_int;
      is_bcd          <= n_bcd;
      operand_size    <= n_size;
      uses_st0_sti    <= n_s0si;
      uses_sti_st0    <= n_sis0;
      valid           <= n_valid;
    end
  end

endmodule

// File: tb/tb_fpu_instruction_decoder.sv
// Self-checking bench for fpu_instruction_decoder: a table-driven model of
// the instruction set, a per-cycle compare against it, and literal checks
// taken from hand-decoded instructions.
module tb_fpu_instruction_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instruction;
  logic        decode;
  logic [7:0]  internal_opcode;
  logic [2:0]  stack_index;
  logic        has_memory_op, has_pop, has_push, is_integer, is_bcd;
  logic [1:0]  operand_size;
  logic        uses_st0_sti, uses_sti_st0, valid;

  int total = 0;
  int bad = 0;
  logic check_en = 1'b0;

  typedef struct packed {
    logic [7:0] op;
    logic [2:0] idx;
    logic       mem;
    logic       pop;
    logic       push;
    logic       int_op;
    logic       bcd;
    logic [1:0] size;
    logic       s0si;
    logic       sis0;
    logic       vld;
  } exp_t;

  exp_t reg_tab [bit [15:0]];
  exp_t mem_tab [bit [5:0]];
  exp_t exp_cur = '0;
  exp_t got;

  fpu_instruction_decoder dut (
    .clk(clk), .reset(reset), .instruction(instruction), .decode(decode),
    .internal_opcode(internal_opcode), .stack_index(stack_index),
    .has_memory_op(has_memory_op), .has_pop(has_pop), .has_push(has_push),
    .is_integer(is_integer), .is_bcd(is_bcd), .operand_size(operand_size),
    .uses_st0_sti(uses_st0_sti), .uses_sti_st0(uses_sti_st0), .valid(valid)
  );

  assign got = {internal_opcode, stack_index, has_memory_op, has_pop, has_push,
                is_integer, is_bcd, operand_size, uses_st0_sti, uses_sti_st0, valid};

  // Free-running clock
  always #5 clk = ~clk;

  function automatic exp_t mk_reg(input logic [7:0] op, input int idx, input bit pop,
                                  input bit push, input bit s0si, input bit sis0);
    exp_t e = '0;
    e.op = op; e.idx = 3'(idx); e.pop = pop; e.push = push;
    e.s0si = s0si; e.sis0 = sis0; e.vld = 1'b1;
    return e;
  endfunction

  function automatic exp_t mk_mem(input logic [7:0] op, input bit pop, input bit push,
                                  input bit int_op, input bit bcd, input int size);
    exp_t e = '0;
    e.op = op; e.mem = 1'b1; e.pop = pop; e.push = push;
    e.int_op = int_op; e.bcd = bcd; e.size = 2'(size); e.vld = 1'b1;
    return e;
  endfunction

  function automatic exp_t model(input logic [15:0] ins);
    exp_t e = '0;
    if (ins[7:6] == 2'b11) begin
      if (reg_tab.exists(ins)) e = reg_tab[ins];
    end else if (ins[15:11] == 5'b11011) begin
      if (mem_tab.exists({ins[10:8], ins[5:3]})) e = mem_tab[{ins[10:8], ins[5:3]}];
    end
    return e;
  endfunction

  // Instruction tables written from the mnemonic listing
  initial begin
    logic [7:0] arith [8];
    logic [7:0] dcop [8];
    logic [7:0] d9e0 [32];
    bit         d9push [32];
    bit         d9pop [32];
    arith = '{8'h10, 8'h16, 8'h60, 8'h61, 8'h12, 8'h14, 8'h18, 8'h1A};
    dcop  = '{8'h10, 8'h16, 8'h60, 8'h61, 8'h14, 8'h12, 8'h1A, 8'h18};
    d9e0  = '{8'h95, 8'h94, 8'h00, 8'h00, 8'h63, 8'h64, 8'h00, 8'h00,
              8'h80, 8'h84, 8'h83, 8'h82, 8'h85, 8'h86, 8'h81, 8'h00,
              8'h56, 8'h57, 8'h54, 8'h55, 8'h98, 8'h00, 8'h71, 8'h70,
              8'h99, 8'h58, 8'h50, 8'h53, 8'h96, 8'h97, 8'h51, 8'h52};
    d9push = '{0,0,0,0,0,0,0,0, 1,1,1,1,1,1,1,0, 0,0,1,0,1,0,0,0, 0,0,0,1,0,0,0,0};
    d9pop  = '{0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0, 0,1,0,1,0,0,0,0, 0,1,0,0,0,0,0,0};

    for (int r = 0; r < 8; r++) begin
      mem_tab[{3'd0, 3'(r)}] = mk_mem(arith[r], r == 3, 0, 0, 0, 1);
      mem_tab[{3'd2, 3'(r)}] = mk_mem(arith[r], r == 3, 0, 1, 0, 1);
      mem_tab[{3'd4, 3'(r)}] = mk_mem(arith[r], r == 3, 0, 0, 0, 2);
      mem_tab[{3'd6, 3'(r)}] = mk_mem(arith[r], r == 3, 0, 1, 0, 0);
    end
    mem_tab[{3'd1, 3'd0}] = mk_mem(8'h20, 0, 1, 0, 0, 1);
    mem_tab[{3'd1, 3'd2}] = mk_mem(8'h21, 0, 0, 0, 0, 1);
    mem_tab[{3'd1, 3'd3}] = mk_mem(8'h22, 1, 0, 0, 0, 1);
    mem_tab[{3'd1, 3'd4}] = mk_mem(8'hF6, 0, 0, 0, 0, 0);
    mem_tab[{3'd1, 3'd5}] = mk_mem(8'hF1, 0, 0, 0, 0, 0);
    mem_tab[{3'd1, 3'd6}] = mk_mem(8'hF7, 0, 0, 0, 0, 0);
    mem_tab[{3'd1, 3'd7}] = mk_mem(8'hF2, 0, 0, 0, 0, 0);
    mem_tab[{3'd3, 3'd0}] = mk_mem(8'h20, 0, 1, 1, 0, 1);
    mem_tab[{3'd3, 3'd2}] = mk_mem(8'h21, 0, 0, 1, 0, 1);
    mem_tab[{3'd3, 3'd3}] = mk_mem(8'h22, 1, 0, 1, 0, 1);
    mem_tab[{3'd3, 3'd5}] = mk_mem(8'h20, 0, 1, 0, 0, 3);
    mem_tab[{3'd3, 3'd7}] = mk_mem(8'h22, 1, 0, 0, 0, 3);
    mem_tab[{3'd5, 3'd0}] = mk_mem(8'h20, 0, 1, 0, 0, 2);
    mem_tab[{3'd5, 3'd2}] = mk_mem(8'h21, 0, 0, 0, 0, 2);
    mem_tab[{3'd5, 3'd3}] = mk_mem(8'h22, 1, 0, 0, 0, 2);
    mem_tab[{3'd5, 3'd4}] = mk_mem(8'hF9, 0, 0, 0, 0, 0);
    mem_tab[{3'd5, 3'd6}] = mk_mem(8'hF8, 0, 0, 0, 0, 0);
    mem_tab[{3'd5, 3'd7}] = mk_mem(8'hF3, 0, 0, 0, 0, 0);
    mem_tab[{3'd7, 3'd0}] = mk_mem(8'h20, 0, 1, 1, 0, 0);
    mem_tab[{3'd7, 3'd2}] = mk_mem(8'h21, 0, 0, 1, 0, 0);
    mem_tab[{3'd7, 3'd3}] = mk_mem(8'h22, 1, 0, 1, 0, 0);
    mem_tab[{3'd7, 3'd4}] = mk_mem(8'h20, 0, 1, 0, 1, 3);
    mem_tab[{3'd7, 3'd5}] = mk_mem(8'h20, 0, 1, 1, 0, 2);
    mem_tab[{3'd7, 3'd6}] = mk_mem(8'h22, 1, 0, 0, 1, 3);
    mem_tab[{3'd7, 3'd7}] = mk_mem(8'h22, 1, 0, 1, 0, 2);

    for (int r = 0; r < 8; r++) begin
      for (int m = 0; m < 8; m++) begin
        logic [7:0] rm8;
        rm8 = 8'hC0 + 8'(r * 8 + m);
        reg_tab[{8'hD8, rm8}] = mk_reg(arith[r], m, r == 3, 0, 1, 0);
        reg_tab[{8'hDC, rm8}] = mk_reg(dcop[r], m, r == 3, 0, 0, 1);
        if (r != 2 && r != 3)
          reg_tab[{8'hDE, rm8}] = mk_reg(arith[r] + 8'h01, m, 1, 0, 0, 1);
      end
    end
    for (int m = 0; m < 8; m++) begin
      reg_tab[{8'hD9, 8'hC0 + 8'(m)}] = mk_reg(8'h20, m, 0, 1, 0, 0);
      reg_tab[{8'hD9, 8'hC8 + 8'(m)}] = mk_reg(8'h23, m, 0, 0, 0, 0);
      reg_tab[{8'hDD, 8'hC0 + 8'(m)}] = mk_reg(8'h72, m, 0, 0, 0, 0);
      reg_tab[{8'hDD, 8'hD0 + 8'(m)}] = mk_reg(8'h21, m, 0, 0, 0, 0);
      reg_tab[{8'hDD, 8'hD8 + 8'(m)}] = mk_reg(8'h22, m, 1, 0, 0, 0);
    end
    reg_tab[16'hD9D0] = mk_reg(8'hF5, 0, 0, 0, 0, 0);
    for (int k = 0; k < 32; k++)
      if (d9e0[k] != 8'h00)
        reg_tab[{8'hD9, 8'hE0 + 8'(k)}] = mk_reg(d9e0[k], 0, d9pop[k], d9push[k], 0, 0);
    reg_tab[16'hDBE2] = mk_reg(8'hF4, 0, 0, 0, 0, 0);
    reg_tab[16'hDBE3] = mk_reg(8'hF0, 0, 0, 0, 0, 0);
    reg_tab[16'hDED9] = mk_reg(8'h62, 1, 1, 0, 0, 0);
    reg_tab[16'hDFE0] = mk_reg(8'hF3, 0, 0, 0, 0, 0);
    reg_tab[16'hDFF6] = mk_reg(8'h71, 6, 0, 0, 0, 0);
    reg_tab[16'hDFF7] = mk_reg(8'h70, 7, 0, 0, 0, 0);
  end

  // Model register: what the outputs must show after each clock edge
  always @(posedge clk) begin
    if (reset) exp_cur <= '0;
    else if (decode) exp_cur <= model(instruction);
  end

  // Per-cycle compare of every output against the model
  always @(negedge clk) begin
    if (check_en) begin
      total++;
      if (got !== exp_cur) begin
        bad++;
        $display("[TB] FAIL cycle_compare instr=%h dut=%h model=%h", instruction, got, exp_cur);
      end
    end
  end

  task automatic apply_stimulus(input logic [15:0] ins, input logic dec);
    @(negedge clk);
    instruction = ins;
    decode = dec;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, want);
    end
  endtask

  // Directed sequence with hand-decoded expectations, then encoding sweeps
  initial begin
    reset = 1'b1;
    decode = 1'b0;
    instruction = 16'h0000;
    @(posedge clk);
    #1;
    check_en = 1'b1;
    @(posedge clk);
    #1;
    check_output("reset_state", 32'(got), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    apply_stimulus(16'hD8C3, 1'b1);
    check_output("d8c3_op", 32'(internal_opcode), 32'h10);
    check_output("d8c3_idx", 32'(stack_index), 32'd3);
    check_output("d8c3_flags", 32'({uses_st0_sti, valid, has_push, has_pop, has_memory_op}), 32'b11000);

    apply_stimulus(16'hDCEC, 1'b1);
    check_output("dcec", 32'({internal_opcode, stack_index, uses_sti_st0}), {20'h0, 8'h12, 3'd4, 1'b1});
    apply_stimulus(16'hDEE3, 1'b1);
    check_output("dee3", 32'({internal_opcode, stack_index, has_pop}), {20'h0, 8'h13, 3'd3, 1'b1});
    apply_stimulus(16'hDED9, 1'b1);
    check_output("ded9", 32'({internal_opcode, stack_index, has_pop}), {20'h0, 8'h62, 3'd1, 1'b1});
    apply_stimulus(16'hD9EB, 1'b1);
    check_output("d9eb", 32'({internal_opcode, stack_index, has_push}), {20'h0, 8'h82, 3'd0, 1'b1});
    apply_stimulus(16'hD9F1, 1'b1);
    check_output("d9f1", 32'({internal_opcode, has_pop}), {23'h0, 8'h57, 1'b1});
    apply_stimulus(16'hDFF7, 1'b1);
    check_output("dff7", 32'({internal_opcode, stack_index}), {21'h0, 8'h70, 3'd7});
    apply_stimulus(16'hDBE3, 1'b1);
    check_output("dbe3", 32'(internal_opcode), 32'hF0);

    apply_stimulus(16'hD906, 1'b1);
    check_output("d906", 32'({internal_opcode, has_memory_op, operand_size, is_integer, has_push}),
                 {19'h0, 8'h20, 1'b1, 2'd1, 1'b0, 1'b1});
    apply_stimulus(16'hDB06, 1'b1);
    check_output("db06", 32'({internal_opcode, operand_size, is_integer, has_push}),
                 {20'h0, 8'h20, 2'd1, 1'b1, 1'b1});
    apply_stimulus(16'hDB2E, 1'b1);
    check_output("db2e", 32'({operand_size, has_push, is_integer}), {27'h0, 2'd3, 1'b1, 1'b0});
    apply_stimulus(16'hDE06, 1'b1);
    check_output("de06", 32'({internal_opcode, is_integer, operand_size, has_memory_op}),
                 {20'h0, 8'h10, 1'b1, 2'd0, 1'b1});
    apply_stimulus(16'hDF36, 1'b1);
    check_output("df36", 32'({internal_opcode, is_bcd, operand_size, has_pop}),
                 {20'h0, 8'h22, 1'b1, 2'd3, 1'b1});

    apply_stimulus(16'hD9D8, 1'b1);
    check_output("d9d8_invalid", 32'(got), 32'h0);
    apply_stimulus(16'hD8C3, 1'b1);
    apply_stimulus(16'h0F00, 1'b1);
    check_output("0f00_invalid", 32'(got), 32'h0);

    apply_stimulus(16'hD8C3, 1'b1);
    apply_stimulus(16'hDCEC, 1'b0);
    apply_stimulus(16'h0F00, 1'b0);
    check_output("hold_op", 32'({internal_opcode, stack_index, valid}), {20'h0, 8'h10, 3'd3, 1'b1});

    apply_stimulus(16'hD9EB, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    instruction = 16'hD8C3;
    decode = 1'b1;
    @(posedge clk);
    #1;
    check_output("reset_beats_decode", 32'(got), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int e = 0; e < 8; e++)
      for (int m = 0; m < 256; m++)
        apply_stimulus({5'b11011, 3'(e), 8'(m)}, (m % 7) != 3);
    apply_stimulus(16'h00C0, 1'b1);
    apply_stimulus(16'hE0C0, 1'b1);
    apply_stimulus(16'hD7FF, 1'b1);

    @(negedge clk);
    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
